// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package divider_pkg;

    // Operand/result width used when the instantiating block does not override it.
    localparam int unsigned DefaultWidth = 4;

    // Divider control states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } div_state_e;

endpackage

// File: rtl/add_sub_unit.sv
// Parameterised ripple-carry adder/subtractor.
// mode_i=0 computes a+b, mode_i=1 computes a-b (b inverted, carry-in 1).
module add_sub_unit #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] b_eff;

    assign b_eff    = b_i ^ {WIDTH{mode_i}};
    assign carry[0] = mode_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum_o[i]     = a_i[i] ^ b_eff[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_eff[i]) | (carry[i] & (a_i[i] ^ b_eff[i]));
    end

    // In subtract mode a carry-out of 1 means the difference is non-negative.
    assign carry_o = carry[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Results and div_by_zero are registered and held until the next accepted start.
module seq_divider
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             zero_pend_q, zero_pend_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;
    logic             accept;
    logic             unused_rem_msb;

    // Restoring never leaves the partial remainder >= divisor, so its MSB is always 0
    // between iterations; only the low WIDTH bits feed the next shift.
    assign unused_rem_msb = rem_q[WIDTH];

    assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

    add_sub_unit #(
        .WIDTH (WIDTH + 1)
    ) u_add_sub (
        .a_i     (shifted),
        .b_i     ({1'b0, dsr_q}),
        .mode_i  (1'b1),
        .sum_o   (trial),
        .carry_o (trial_ok)
    );

    assign rem_step = trial_ok ? trial : shifted;
    assign quo_step = {quo_q[WIDTH-2:0], trial_ok};

    // A zero-divisor request occupies one internal cycle before done, so it also blocks start.
    assign accept = start_i && (state_q != StRun) && !zero_pend_q;

    // Next-state, datapath and result register updates.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        cnt_d       = cnt_q;
        zero_pend_d = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (zero_pend_q) begin
                    // quo_q still holds the dividend loaded at acceptance.
                    state_d     = StDone;
                    quotient_d  = '1;
                    remainder_d = quo_q;
                    dbz_d       = 1'b1;
                end
            end
            StRun: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    state_d     = StDone;
                    quotient_d  = quo_step;
                    remainder_d = rem_step[WIDTH-1:0];
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            rem_d = '0;
            quo_d = dividend_i;
            dsr_d = divisor_i;
            cnt_d = CntW'(WIDTH);
            dbz_d = 1'b0;
            if (divisor_i == '0) begin
                state_d     = StIdle;
                zero_pend_d = 1'b1;
            end else begin
                state_d = StRun;
            end
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            zero_pend_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            cnt_q       <= cnt_d;
            zero_pend_q <= zero_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy_o        = (state_q == StRun);
    assign done_o        = (state_q == StDone);
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = dbz_q;

endmodule
